// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Decode-to-execute issue stage for the single-issue MIPS core. Decodes the
//   ALU subset of the instruction set into a one-hot ALU control word and the
//   two ALU operands, plus writeback destination information. The stage is a
//   registered valid/ready stage: a main register drives the outputs, and a
//   skid register absorbs one extra entry while the main register is stalled.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     upstream has an instruction
//   in_ready     stage can accept (registered, equals NOT skid occupied)
//   inst         instruction word
//   rs_value     GPR[rs], valid with in_valid
//   rt_value     GPR[rt], valid with in_valid
//   flush        synchronous kill of all held entries (highest priority)
//   out_valid    issued entry valid
//   out_ready    execute stage accepts
//   alu_control  one-hot: [0]add [1]sub [2]slt [3]sltu [4]and [5]nor
//                [6]or [7]xor [8]sll [9]srl [10]sra [11]lui
//   alu_src1     ALU operand 1 (shift amount in [4:0] for shifts)
//   alu_src2     ALU operand 2 (value shifted for shifts, imm for lui)
//   dest         destination GPR
//   wen          register write enable (0 for dest==0 or illegal)
//   illegal      instruction is outside the supported subset

module alu_issue_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] alu_control,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [4:0]  dest,
  output logic        wen,
  output logic        illegal
);

  // Bit position of each operation within alu_control.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic [11:0] ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dest;
    logic        wen;
    logic        illegal;
  } entry_t;

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign op       = inst[31:26];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign sa       = inst[10:6];
  assign funct    = inst[5:0];
  assign imm      = inst[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  // The rs field only selects which register was read upstream.
  logic unused_rs_field;
  assign unused_rs_field = ^inst[25:21];

  entry_t  dec;
  alu_op_e dec_op;
  logic    dec_legal;

  always_comb begin
    dec       = '0;
    dec_op    = ALU_ADD;
    dec_legal = 1'b1;
    dec.src1  = rs_value;
    dec.src2  = rt_value;
    dec.dest  = rd;

    if (op == 6'h00) begin
      case (funct)
        6'h20, 6'h21: dec_op = ALU_ADD;
        6'h22, 6'h23: dec_op = ALU_SUB;
        6'h2A:        dec_op = ALU_SLT;
        6'h2B:        dec_op = ALU_SLTU;
        6'h24:        dec_op = ALU_AND;
        6'h25:        dec_op = ALU_OR;
        6'h26:        dec_op = ALU_XOR;
        6'h27:        dec_op = ALU_NOR;
        6'h00: begin
          dec_op   = ALU_SLL;
          dec.src1 = {27'd0, sa};
        end
        6'h02: begin
          dec_op   = ALU_SRL;
          dec.src1 = {27'd0, sa};
        end
        6'h03: begin
          dec_op   = ALU_SRA;
          dec.src1 = {27'd0, sa};
        end
        6'h04:        dec_op = ALU_SLL;
        6'h06:        dec_op = ALU_SRL;
        6'h07:        dec_op = ALU_SRA;
        default:      dec_legal = 1'b0;
      endcase
    end else begin
      dec.dest = rt;
      case (op)
        6'h08, 6'h09: begin
          dec_op   = ALU_ADD;
          dec.src2 = imm_sext;
        end
        6'h0A: begin
          dec_op   = ALU_SLT;
          dec.src2 = imm_sext;
        end
        6'h0B: begin
          dec_op   = ALU_SLTU;
          dec.src2 = imm_sext;
        end
        6'h0C: begin
          dec_op   = ALU_AND;
          dec.src2 = imm_zext;
        end
        6'h0D: begin
          dec_op   = ALU_OR;
          dec.src2 = imm_zext;
        end
        6'h0E: begin
          dec_op   = ALU_XOR;
          dec.src2 = imm_zext;
        end
        6'h0F: begin
          dec_op   = ALU_LUI;
          dec.src1 = '0;
          dec.src2 = imm_zext;
        end
        default: dec_legal = 1'b0;
      endcase
    end

    if (dec_legal) begin
      dec.ctrl = 12'd1 << dec_op;
      dec.wen  = (dec.dest != 5'd0);
    end else begin
      // Illegal entries still flow through, with all data fields cleared.
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Main + skid buffering
  // ---------------------------------------------------------------------
  entry_t main_q;
  entry_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   accept;
  logic   drain;

  assign accept = in_valid & in_ready & ~flush;
  assign drain  = main_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (!main_valid || drain) begin
      if (skid_valid) begin
        // Skid is older than any new accept, so it refills main first.
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= accept;
        in_ready   <= ~accept;
        if (accept) begin
          skid_q <= dec;
        end
      end else begin
        main_valid <= accept;
        in_ready   <= 1'b1;
        if (accept) begin
          main_q <= dec;
        end
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
      in_ready   <= 1'b0;
    end
  end

  assign out_valid   = main_valid;
  assign alu_control = main_q.ctrl;
  assign alu_src1    = main_q.src1;
  assign alu_src2    = main_q.src2;
  assign dest        = main_q.dest;
  assign wen         = main_q.wen;
  assign illegal     = main_q.illegal;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute issue stage for the single-issue MIPS core. It accepts a fetched instruction with its register-file read values and decodes the ALU subset. It emits the 12-bit one-hot `alu_control` and the `alu_src1`/`alu_src2` operands in the exact form the ALU consumes, plus writeback destination information. The stage is a registered valid/ready pipeline stage with a two-entry skid buffer and a synchronous flush.

## Interface
- No parameters; all widths fixed (32-bit datapath, 12-bit control).
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  stage can accept; registered (equals NOT skid_valid).
- `inst`  in  32  instruction word.
- `rs_value`  in  32  GPR[rs], valid with `in_valid`.
- `rt_value`  in  32  GPR[rt], valid with `in_valid`.
- `flush`  in  1  synchronous kill of all held entries.
- `out_valid`  out  1  issued entry valid.
- `out_ready`  in  1  execute stage accepts.
- `alu_control`  out  12  one-hot: [0]add [1]sub [2]slt [3]sltu [4]and [5]nor [6]or [7]xor [8]sll [9]srl [10]sra [11]lui.
- `alu_src1`  out  32  ALU operand 1. For shifts, bits [4:0] are the shift amount.
- `alu_src2`  out  32  ALU operand 2. For shifts, this is the value shifted. For lui, bits [15:0] are the immediate.
- `dest`  out  5  destination GPR.
- `wen`  out  1  register write enable; 0 when `dest`==0 or the instruction is illegal.
- `illegal`  out  1  instruction is not in the supported subset.

## Operation
- Decode fields: op=inst[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sa=[10:6], funct=[5:0], imm=[15:0].
- R-type (op=0), funct -> control / src1 / src2, dest=rd:
  - 0x20/0x21 add.
  - 0x22/0x23 sub.
  - 0x2A slt.
  - 0x2B sltu.
  - 0x24 and.
  - 0x25 or.
  - 0x26 xor.
  - 0x27 nor.
  - For all of the above: src1=rs_value, src2=rt_value.
  - 0x00 sll, 0x02 srl, 0x03 sra: src1={27'b0,sa}, src2=rt_value.
  - 0x04 sllv, 0x06 srlv, 0x07 srav: src1=rs_value, src2=rt_value.
- I-type, dest=rt, src1=rs_value:
  - 0x08/0x09 add, sign-extended imm.
  - 0x0A slt, sign-extended imm.
  - 0x0B sltu, sign-extended imm.
  - 0x0C and, zero-extended imm.
  - 0x0D or, zero-extended imm.
  - 0x0E xor, zero-extended imm.
  - 0x0F lui: src1=0, src2={16'b0,imm}.
- No overflow trap; add/addu and addi/addiu decode identically.
- Any other op/funct: alu_control=12'h000, src1=src2=0, dest=0, wen=0, illegal=1. The entry still flows through the stage.
- Exactly one `alu_control` bit is set for every legal instruction; none for illegal.
- Buffering: main register (drives outputs) plus one skid register. Entries leave in acceptance order; no loss, no duplication.
  - Accept when in_valid & in_ready & ~flush.
  - Accepted entry goes to main if main is empty or draining (out_ready); otherwise it goes to skid.
  - When main drains and skid is valid, skid moves to main the same edge, and a new accept then goes to skid.
- flush: at the next edge main_valid=skid_valid=0. An input presented in the flush cycle is discarded even if in_ready=1. Flush has priority over all other updates.

## Timing
- Reset values (asynchronous, immediate):
  - out_valid=0, in_ready=1.
  - alu_control=0, alu_src1=0, alu_src2=0, dest=0.
  - wen=0, illegal=0.
  - Skid empty.
- Latency: an accept at edge N gives out_valid=1 with decoded data after edge N (one cycle).
- Throughput: one instruction per cycle when out_ready is held high.
- Output data is stable while out_valid & ~out_ready.
- in_ready falls the cycle after an entry enters skid. It rises the cycle after skid empties.
- A transfer completes on an edge where out_valid & out_ready; a simultaneous accept refills main the same edge.
- Reset asserted mid-stream drops all entries immediately.
- Data-out fields of an invalid entry are don't-care except after reset.

## Test plan
- `inst`=0x00851020 (add $2,$4,$5), rs_value=7, rt_value=9, out_ready=1 -> the next cycle shows out_valid=1, alu_control=12'h001, src1=7, src2=9, dest=2, wen=1, illegal=0.
- `inst`=0x00061903 (sra $3,$6,4), rt_value=0x80000000 -> alu_control=12'h400, src1=4, src2=0x80000000, dest=3.
- 0x3C011234 (lui $1,0x1234) -> control 12'h800, src2=0x00001234, dest=1. 0x2002FFFF (addi $2,$0,-1) -> control 12'h001, src2=0xFFFFFFFF. 0x30428000 (andi $2,$2,0x8000) -> control 12'h010, src2=0x00008000.
- `inst`=0xFC000000 -> illegal=1, alu_control=0, wen=0. `inst`=0x00000020 (add $0,$0,$0) -> wen=0, alu_control=12'h001.
- Stream 6 instructions back-to-back with out_ready low for 3 cycles mid-stream -> in_ready drops after 2 pending accepts; all 6 emerge in order, unchanged, with no duplicates.
- Fill main and skid, then assert flush together with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed-cycle input never appears. Assert reset mid-stream -> outputs go to their reset values immediately.
